// File: rtl/extio8x4_pkg.sv
// Shared constants and types for the extio8x4 initiator scheduler.
// Channel codes match the 2-bit transfer command seen by the initiator FSM.
package extio8x4_pkg;

    localparam int NCH = 4;

    localparam logic [1:0] CH_RX0 = 2'b00;
    localparam logic [1:0] CH_TX0 = 2'b01;
    localparam logic [1:0] CH_RX1 = 2'b10;
    localparam logic [1:0] CH_TX1 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_BUSY  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/extio8x4_rr_pick.sv
// Rotating find-first: returns the first set mask bit after the pointer,
// wrapping, with the pointer position itself checked last.
module extio8x4_rr_pick
    import extio8x4_pkg::*;
(
    input  logic [NCH-1:0] mask_i,
    input  logic [1:0]     ptr_i,
    output logic           found_o,
    output logic [1:0]     idx_o
);

    logic [1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int i = 1; i <= NCH; i++) begin
            cand = ptr_i + 2'(i);
            if (!found_o && mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/extio8x4_wrr_sched.sv
// Weighted round-robin scheduler for the four extio8x4 virtual channels,
// with per-channel burst credits and a starvation guard.
//
// state   | meaning
// S_IDLE  | no command offered; arbitrate when any channel is eligible
// S_OFFER | command held on sched_valid_o/sched_code_o until accepted or withdrawn
// S_BUSY  | transfer accepted; waiting for xfer_done_i
module extio8x4_wrr_sched
    import extio8x4_pkg::*;
#(
    parameter int WEIGHT_W = 4,
    parameter int STARVE_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req_i,
    input  logic [4*WEIGHT_W-1:0]   cfg_weight_i,
    input  logic [STARVE_W-1:0]     cfg_starve_lim_i,
    output logic                    sched_valid_o,
    output logic [1:0]              sched_code_o,
    input  logic                    sched_ready_i,
    input  logic                    xfer_done_i,
    output logic                    busy_o,
    output logic                    proto_err_o
);

    sched_state_e        state_q, state_d;
    logic [1:0]          code_q, code_d;
    logic [1:0]          ptr_q, ptr_d;
    logic                err_q, err_d;
    logic [WEIGHT_W-1:0] credit_q [NCH];
    logic [WEIGHT_W-1:0] credit_d [NCH];
    logic [STARVE_W-1:0] starve_q [NCH];
    logic [STARVE_W-1:0] starve_d [NCH];

    logic [WEIGHT_W-1:0] weight [NCH];
    logic [NCH-1:0]      elig;
    logic [NCH-1:0]      starving;
    logic                starve_any;
    logic [1:0]          starve_idx;
    logic                pick_found;
    logic [1:0]          pick_idx;

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            weight[n]   = cfg_weight_i[n*WEIGHT_W +: WEIGHT_W];
            elig[n]     = req_i[n] && (weight[n] != '0);
            starving[n] = elig[n] && (cfg_starve_lim_i != '0)
                          && (starve_q[n] >= cfg_starve_lim_i);
        end
    end

    // Lowest index wins among starving channels.
    always_comb begin
        starve_any = 1'b0;
        starve_idx = 2'd0;
        for (int n = NCH - 1; n >= 0; n--) begin
            if (starving[n]) begin
                starve_any = 1'b1;
                starve_idx = 2'(n);
            end
        end
    end

    extio8x4_rr_pick u_rr_pick (
        .mask_i  (elig),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        credit_d = credit_q;
        starve_d = starve_q;

        case (state_q)
            S_IDLE: begin
                if (sched_ready_i || xfer_done_i) err_d = 1'b1;
                if (|elig) begin
                    state_d = S_OFFER;
                    if (starve_any) begin
                        code_d               = starve_idx;
                        ptr_d                = starve_idx;
                        credit_d[starve_idx] = weight[starve_idx];
                    end else if (elig[ptr_q] && (credit_q[ptr_q] != '0)) begin
                        code_d = ptr_q;
                    end else if (pick_found) begin
                        code_d             = pick_idx;
                        ptr_d              = pick_idx;
                        credit_d[pick_idx] = weight[pick_idx];
                    end
                end
            end

            S_OFFER: begin
                if (xfer_done_i) err_d = 1'b1;
                if (sched_ready_i) begin
                    state_d = S_BUSY;
                    if (credit_q[code_q] != '0)
                        credit_d[code_q] = credit_q[code_q] - WEIGHT_W'(1);
                    for (int n = 0; n < NCH; n++) begin
                        if (2'(n) == code_q)
                            starve_d[n] = '0;
                        else if (elig[n] && (starve_q[n] != '1))
                            starve_d[n] = starve_q[n] + STARVE_W'(1);
                    end
                end else if (!req_i[code_q]) begin
                    state_d = S_IDLE;
                end
            end

            S_BUSY: begin
                if (sched_ready_i) err_d = 1'b1;
                if (xfer_done_i) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= CH_RX0;
            ptr_q   <= CH_TX1;
            err_q   <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                credit_q[n] <= '0;
                starve_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            credit_q <= credit_d;
            starve_q <= starve_d;
        end
    end

    assign sched_valid_o = (state_q == S_OFFER);
    assign busy_o        = (state_q == S_BUSY);
    assign sched_code_o  = code_q;
    assign proto_err_o   = err_q;

endmodule

// File: doc/extio8x4_wrr_sched.md
Name: extio8x4_wrr_sched

Overview:
Weighted round-robin scheduler for the extio8x4 initiator's four virtual channels: rx0 write, tx0 read, rx1 write and tx1 read. It replaces the fixed 12-slot fair-priority pattern with programmable per-channel burst weights and a starvation guard. It issues one 2-bit transfer command at a time to the initiator FSM and tracks that transfer until completion. It sits between the per-channel request qualifiers (status-phase flow control) and the initiator sequencer.

Parameters:
WEIGHT_W, 4, width of each per-channel weight/credit field
STARVE_W, 8, width of starvation counters and limit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_i  in  4  qualified requests; bit0=rx0 (code 00), bit1=tx0 (01), bit2=rx1 (10), bit3=tx1 (11)
cfg_weight_i  in  4*WEIGHT_W  per-channel weight, channel n at [n*WEIGHT_W +: WEIGHT_W]; 0 = channel disabled
cfg_starve_lim_i  in  STARVE_W  starvation limit; 0 = guard disabled
sched_valid_o  out  1  command offered
sched_code_o  out  2  channel code of offered/active command
sched_ready_i  in  1  initiator accepts command (start of transfer)
xfer_done_i  in  1  1-cycle pulse, transfer complete
busy_o  out  1  transfer outstanding
proto_err_o  out  1  sticky protocol error

Behaviour:
- Reset (sync, active-high): state IDLE; sched_valid_o=0, sched_code_o=00, busy_o=0, proto_err_o=0; rr pointer=3 (so the first search starts at channel 0); all credits=0; all starve counters=0. Reset mid-transfer discards the outstanding command with no completion reported.
- eligible[n] = req_i[n] & (weight[n]!=0).
- States: IDLE, OFFER, BUSY.
- IDLE: if any eligible channel exists, choose a winner and register it into sched_code_o. Go to OFFER; sched_valid_o=1 from the next cycle (1-cycle arbitration latency).
- Winner selection, in priority order:
  (a) starving channel: eligible & starve_cnt>=lim & lim!=0; lowest index wins.
  (b) current pointer channel, if eligible and credit>0.
  (c) next eligible channel searching ptr+1, ptr+2, ... with wrap modulo 4; ptr moves to it and its credit reloads to weight.
  Case (a) moves ptr to the winner and reloads credit.
- Weights are sampled only at credit reload; a mid-burst change takes effect at the next reload.
- OFFER: sched_valid_o and sched_code_o are held stable.
  - sched_ready_i=1: go to BUSY; sched_valid_o=0; busy_o=1; winner credit decrements (saturating at 0); winner starve_cnt clears; every other eligible channel's starve_cnt increments, saturating at all-ones.
  - req_i[winner] drops with ready=0: withdraw; sched_valid_o=0; back to IDLE; no credit or counter change.
  - Ready and request-drop in the same cycle: ready wins.
- BUSY: wait for xfer_done_i, then IDLE with busy_o=0. A new arbitration may start in that same IDLE cycle, giving minimum 2 cycles from done to the next valid.
- xfer_done_i in IDLE or OFFER, or sched_ready_i in IDLE or BUSY: set proto_err_o (sticky until reset). The event is otherwise ignored.
- Ineligible channels' starve counters hold their value; they do not clear.
- All state lives in registers; outputs are register-driven (no combinational input-to-output paths).

Decomposition:
- Package extio8x4_pkg:
  - channel code constants CH_RX0=2'b00, CH_TX0=2'b01, CH_RX1=2'b10, CH_TX1=2'b11
  - scheduler state encoding (IDLE/OFFER/BUSY)
  - NCH=4
- Sub-module extio8x4_rr_pick: combinational rotating find-first. Inputs: 4-bit mask, 2-bit pointer. Outputs: found, 2-bit index of first set bit after pointer, with wrap. Reused for case (c); case (a) uses a plain lowest-index priority encoder.

Test Plan:
- Weights all 1, req_i=4'b1111 held, ready asserted the cycle after valid, done 3 cycles later → codes 00,01,10,11,00,… in strict rotation; proto_err_o=0.
- Weights rx0=3, tx1=1, others 0; req_i=4'b1001 → code sequence 00,00,00,11,00,00,00,11.
- Weight tx0=0, req_i=4'b0010 only → sched_valid_o stays 0 for 50 cycles.
- Weights rx0=15, rx1=1, lim=4, req_i=4'b0101 → rx1 (10) granted no later than after 4 consecutive rx0 grants; rx1 starve counter clears on its grant.
- OFFER with code 01, then req_i[1] deasserted before ready → valid drops next cycle, state IDLE, tx0 credit unchanged; re-asserting req re-offers 01.
- xfer_done_i pulsed in IDLE → proto_err_o=1 and held; reset asserted during BUSY → next cycle busy_o=0, sched_valid_o=0, proto_err_o=0, first grant after reset is the lowest eligible index.
